// File: rtl/ccip_mmio_csr_pkg.sv
// Shared types and register map for the CCI-P MMIO CSR block.
// The CCI-P structs here carry only the c0 MMIO request and c2 response fields the block uses.
package ccip_mmio_csr_pkg;

    localparam int OFS_DFH      = 'h000;
    localparam int OFS_ID_L     = 'h008;
    localparam int OFS_ID_H     = 'h010;
    localparam int OFS_SCRATCH  = 'h028;
    localparam int OFS_MODE     = 'h030;
    localparam int OFS_USR_BASE = 'h040;
    localparam int OFS_RD_CNT   = 'h100;
    localparam int OFS_WR_CNT   = 'h108;
    localparam int OFS_BAD_CNT  = 'h110;

    localparam int MAX_USR_CSR = 16;

    typedef logic [$clog2(MAX_USR_CSR)-1:0] t_csr_idx;
    typedef logic [14:0] t_reg_idx;

    // Register index is the 64-bit word number, i.e. byte offset / 8.
    localparam t_reg_idx IDX_DFH      = t_reg_idx'(OFS_DFH >> 3);
    localparam t_reg_idx IDX_ID_L     = t_reg_idx'(OFS_ID_L >> 3);
    localparam t_reg_idx IDX_ID_H     = t_reg_idx'(OFS_ID_H >> 3);
    localparam t_reg_idx IDX_SCRATCH  = t_reg_idx'(OFS_SCRATCH >> 3);
    localparam t_reg_idx IDX_MODE     = t_reg_idx'(OFS_MODE >> 3);
    localparam t_reg_idx IDX_USR_BASE = t_reg_idx'(OFS_USR_BASE >> 3);
    localparam t_reg_idx IDX_RD_CNT   = t_reg_idx'(OFS_RD_CNT >> 3);
    localparam t_reg_idx IDX_WR_CNT   = t_reg_idx'(OFS_WR_CNT >> 3);
    localparam t_reg_idx IDX_BAD_CNT  = t_reg_idx'(OFS_BAD_CNT >> 3);

    typedef struct packed {
        logic [15:0] address;
        logic [1:0]  length;
        logic [8:0]  tid;
    } t_ccip_c0_ReqMmioHdr;

    typedef struct packed {
        logic                mmioRdValid;
        logic                mmioWrValid;
        t_ccip_c0_ReqMmioHdr hdr;
        logic [63:0]         data;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        t_if_ccip_c0_Rx c0;
    } t_if_ccip_Rx;

    typedef struct packed {
        logic [8:0] tid;
    } t_ccip_c2_RspMmioHdr;

    typedef struct packed {
        logic                mmioRdValid;
        t_ccip_c2_RspMmioHdr hdr;
        logic [63:0]         data;
    } t_if_ccip_c2_Tx;

    typedef struct packed {
        logic        valid;
        logic        is_rd;
        logic        is_wr;
        logic        is_4b;
        t_reg_idx    idx;
        logic        dsel;
        logic [8:0]  tid;
        logic [63:0] data;
    } t_mmio_stage;

    // A 4B write carries its dword in data[31:0] and lands in the half chosen by dsel.
    function automatic logic [63:0] mergeWr(input logic [63:0] oldQ, input logic [63:0] wData,
                                            input logic is4b, input logic dsel);
        if (!is4b) return wData;
        return dsel ? {wData[31:0], oldQ[31:0]} : {oldQ[63:32], wData[31:0]};
    endfunction

endpackage

// File: rtl/ccip_mmio_stats.sv
// Wrapping MMIO access counters; only compiled when CCIP_MMIO_STATS_EN is defined.
`ifdef CCIP_MMIO_STATS_EN
module ccip_mmio_stats (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_rd,
    input  logic        i_wr,
    input  logic        i_badRd,
    input  logic        i_badWr,
    input  logic        i_clr,
    output logic [31:0] o_rdCnt,
    output logic [31:0] o_wrCnt,
    output logic [31:0] o_badCnt
);

    logic [31:0] r_rdCnt;
    logic [31:0] r_wrCnt;
    logic [31:0] r_badCnt;

    // Clear has priority so the clearing write never shows up in the counts.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr) begin
            r_rdCnt  <= '0;
            r_wrCnt  <= '0;
            r_badCnt <= '0;
        end else begin
            r_rdCnt  <= r_rdCnt + 32'(i_rd);
            r_wrCnt  <= r_wrCnt + 32'(i_wr);
            r_badCnt <= r_badCnt + 32'(i_badRd) + 32'(i_badWr);
        end
    end

    assign o_rdCnt  = r_rdCnt;
    assign o_wrCnt  = r_wrCnt;
    assign o_badCnt = r_badCnt;

endmodule
`endif

// File: rtl/ccip_mmio_csr_block.sv
// CCI-P MMIO CSR block: DFH/ID, scratch, mode and user CSRs with a fixed 2-cycle read pipeline.
// Define CCIP_MMIO_STATS_EN to add RD/WR/BAD access counters at 0x100-0x110.
module ccip_mmio_csr_block
    import ccip_mmio_csr_pkg::*;
#(
    parameter logic [63:0] AFU_DFH     = 64'h1000_0000_0000_0001,
    parameter logic [63:0] AFU_ID_L    = 64'h0,
    parameter logic [63:0] AFU_ID_H    = 64'h0,
    parameter int          NUM_USR_CSR = 8
) (
    input  logic                       pClk,
    input  logic                       pReset,
    input  t_if_ccip_Rx                pck_cp2af_sRx,
    output t_if_ccip_c2_Tx             c2_tx,
    input  logic [63:0]                mode_status,
    output logic [64*NUM_USR_CSR-1:0]  usr_csr,
    output logic                       usr_csr_wr_valid,
    output t_csr_idx                   usr_csr_wr_idx
);

    t_mmio_stage    w_req;
    t_mmio_stage    r_s1;
    t_if_ccip_c2_Tx r_c2;
    logic [63:0]    r_scratch;
    logic [63:0]    r_usrCsr [NUM_USR_CSR];
    logic           r_wrValid;
    t_csr_idx       r_wrIdx;
    logic           w_rdEn;
    logic           w_wrEn;
    logic           w_usrHit;
    t_csr_idx       w_usrSel;
    logic [63:0]    w_usrQ;
    logic [63:0]    w_regQ;
    logic [63:0]    w_rdData;

`ifdef CCIP_MMIO_STATS_EN
    logic        w_rdMapped;
    logic        w_wrOk;
    logic        w_clr;
    logic [31:0] w_rdCnt;
    logic [31:0] w_wrCnt;
    logic [31:0] w_badCnt;
`endif

    always_comb begin
        w_req       = '0;
        w_req.is_rd = pck_cp2af_sRx.c0.mmioRdValid;
        w_req.is_wr = pck_cp2af_sRx.c0.mmioWrValid;
        w_req.valid = pck_cp2af_sRx.c0.mmioRdValid | pck_cp2af_sRx.c0.mmioWrValid;
        w_req.is_4b = (pck_cp2af_sRx.c0.hdr.length == 2'd0);
        w_req.idx   = pck_cp2af_sRx.c0.hdr.address[15:1];
        w_req.dsel  = pck_cp2af_sRx.c0.hdr.address[0];
        w_req.tid   = pck_cp2af_sRx.c0.hdr.tid;
        w_req.data  = pck_cp2af_sRx.c0.data;
    end

    always_ff @(posedge pClk) begin
        if (pReset) r_s1 <= '0;
        else        r_s1 <= w_req;
    end

    assign w_rdEn = r_s1.valid & r_s1.is_rd;
    assign w_wrEn = r_s1.valid & r_s1.is_wr;

    always_comb begin
        w_usrHit = 1'b0;
        w_usrSel = '0;
        w_usrQ   = '0;
        for (int i = 0; i < NUM_USR_CSR; i++) begin
            if (r_s1.idx == t_reg_idx'(IDX_USR_BASE + i)) begin
                w_usrHit = 1'b1;
                w_usrSel = t_csr_idx'(i);
                w_usrQ   = r_usrCsr[i];
            end
        end
    end

`ifdef CCIP_MMIO_STATS_EN
    always_comb begin
        w_clr      = w_wrEn && (r_s1.idx == IDX_RD_CNT);
        w_wrOk     = (r_s1.idx == IDX_SCRATCH) || w_usrHit || (r_s1.idx == IDX_RD_CNT);
        w_rdMapped = (r_s1.idx <= IDX_MODE) || w_usrHit ||
                     (r_s1.idx >= IDX_RD_CNT && r_s1.idx <= IDX_BAD_CNT);
    end

    ccip_mmio_stats u_stats (
        .i_clk    (pClk),
        .i_reset  (pReset),
        .i_rd     (w_rdEn),
        .i_wr     (w_wrEn),
        .i_badRd  (w_rdEn & ~w_rdMapped),
        .i_badWr  (w_wrEn & ~w_wrOk),
        .i_clr    (w_clr),
        .o_rdCnt  (w_rdCnt),
        .o_wrCnt  (w_wrCnt),
        .o_badCnt (w_badCnt)
    );
`endif

    // Reads see state before any write in the same stage, since writes commit at the end of it.
    always_comb begin
        w_regQ = '0;
        case (r_s1.idx)
            IDX_DFH:     w_regQ = AFU_DFH;
            IDX_ID_L:    w_regQ = AFU_ID_L;
            IDX_ID_H:    w_regQ = AFU_ID_H;
            IDX_SCRATCH: w_regQ = r_scratch;
            IDX_MODE:    w_regQ = mode_status;
`ifdef CCIP_MMIO_STATS_EN
            IDX_RD_CNT:  w_regQ = {32'd0, w_rdCnt};
            IDX_WR_CNT:  w_regQ = {32'd0, w_wrCnt};
            IDX_BAD_CNT: w_regQ = {32'd0, w_badCnt};
`endif
            default:     w_regQ = w_usrHit ? w_usrQ : 64'd0;
        endcase
        if (!r_s1.is_4b)    w_rdData = w_regQ;
        else if (r_s1.dsel) w_rdData = {2{w_regQ[63:32]}};
        else                w_rdData = {2{w_regQ[31:0]}};
    end

    always_ff @(posedge pClk) begin
        if (pReset) begin
            r_scratch <= '0;
            for (int i = 0; i < NUM_USR_CSR; i++) r_usrCsr[i] <= '0;
            r_wrValid <= 1'b0;
            r_wrIdx   <= '0;
        end else begin
            r_wrValid <= 1'b0;
            if (w_wrEn && r_s1.idx == IDX_SCRATCH)
                r_scratch <= mergeWr(r_scratch, r_s1.data, r_s1.is_4b, r_s1.dsel);
            if (w_wrEn && w_usrHit) begin
                for (int i = 0; i < NUM_USR_CSR; i++) begin
                    if (w_usrSel == t_csr_idx'(i))
                        r_usrCsr[i] <= mergeWr(r_usrCsr[i], r_s1.data, r_s1.is_4b, r_s1.dsel);
                end
                r_wrValid <= 1'b1;
                r_wrIdx   <= w_usrSel;
            end
        end
    end

    always_ff @(posedge pClk) begin
        if (pReset) begin
            r_c2 <= '0;
        end else begin
            r_c2 <= '0;
            if (w_rdEn) begin
                r_c2.mmioRdValid <= 1'b1;
                r_c2.hdr.tid     <= r_s1.tid;
                r_c2.data        <= w_rdData;
            end
        end
    end

    for (genvar g = 0; g < NUM_USR_CSR; g++) begin : g_usrOut
        assign usr_csr[64*g +: 64] = r_usrCsr[g];
    end

    assign c2_tx            = r_c2;
    assign usr_csr_wr_valid = r_wrValid;
    assign usr_csr_wr_idx   = r_wrIdx;

endmodule

// File: tb/tb_ccip_mmio_csr_block.sv
// Self-checking bench for ccip_mmio_csr_block: directed cases plus random MMIO traffic
// scored against a register-map model with per-cycle response and pulse timing checks.
module tb_ccip_mmio_csr_block;
    import ccip_mmio_csr_pkg::*;

    localparam int          NUSR = 8;
    localparam logic [63:0] DFH  = 64'h1000_0000_0000_0001;
    localparam logic [63:0] IDL  = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] IDH  = 64'hFEDC_BA98_7654_3210;

    logic                 pClk = 1'b0;
    logic                 pReset;
    t_if_ccip_Rx          rx;
    t_if_ccip_c2_Tx       c2;
    logic [63:0]          modeStatus;
    logic [64*NUSR-1:0]   usrCsr;
    logic                 wrValid;
    t_csr_idx             wrIdx;

    int checkCount = 0;
    int errCount   = 0;
    int edgeNum    = 0;

    logic [63:0] mScratch;
    logic [63:0] mUsr [NUSR];
`ifdef CCIP_MMIO_STATS_EN
    logic [31:0] mRdCnt;
    logic [31:0] mWrCnt;
    logic [31:0] mBadCnt;
`endif

    typedef struct { int due; logic [8:0] tid; logic [63:0] data; } rsp_t;
    typedef struct { int due; int idx; } pulse_t;
    rsp_t   rspQ[$];
    pulse_t pulseQ[$];

    ccip_mmio_csr_block #(
        .AFU_DFH     (DFH),
        .AFU_ID_L    (IDL),
        .AFU_ID_H    (IDH),
        .NUM_USR_CSR (NUSR)
    ) dut (
        .pClk             (pClk),
        .pReset           (pReset),
        .pck_cp2af_sRx    (rx),
        .c2_tx            (c2),
        .mode_status      (modeStatus),
        .usr_csr          (usrCsr),
        .usr_csr_wr_valid (wrValid),
        .usr_csr_wr_idx   (wrIdx)
    );

    always #5 pClk = ~pClk;
    always @(posedge pClk) edgeNum++;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%016h expected 0x%016h (edge %0d)", tag, obs, exp, edgeNum);
        end
    endtask

    function automatic logic [63:0] modelRead(input int base, output bit mapped);
        mapped = 1'b1;
        if (base == 'h00) return DFH;
        if (base == 'h08) return IDL;
        if (base == 'h10) return IDH;
        if (base == 'h18 || base == 'h20) return 64'd0;
        if (base == 'h28) return mScratch;
        if (base == 'h30) return modeStatus;
        if (base >= 'h40 && base < 'h40 + 8*NUSR) return mUsr[(base - 'h40) / 8];
`ifdef CCIP_MMIO_STATS_EN
        if (base == 'h100) return {32'd0, mRdCnt};
        if (base == 'h108) return {32'd0, mWrCnt};
        if (base == 'h110) return {32'd0, mBadCnt};
`endif
        mapped = 1'b0;
        return 64'd0;
    endfunction

    function automatic logic [63:0] modelMerge(input logic [63:0] oldV, input logic [63:0] d,
                                               input bit is4, input bit hi);
        logic [63:0] r;
        if (!is4) return d;
        r = oldV;
        if (hi) r[63:32] = d[31:0];
        else    r[31:0]  = d[31:0];
        return r;
    endfunction

    // Each request is resolved read-before-write against the model the moment it is issued.
    task automatic modelAccept(input bit rd, input bit wr, input logic [15:0] addr,
                               input logic [1:0] len, input logic [8:0] tid, input logic [63:0] data);
        int base;
        int idx;
        bit is4;
        bit hi;
        bit mapped;
        logic [63:0] q;
`ifdef CCIP_MMIO_STATS_EN
        bit badRd = 1'b0;
        bit badWr = 1'b0;
        bit clr   = 1'b0;
`endif
        base = (int'(addr) * 4) & ~7;
        is4  = (len == 2'd0);
        hi   = addr[0];
        if (rd) begin
            q = modelRead(base, mapped);
            if (is4) q = hi ? {q[63:32], q[63:32]} : {q[31:0], q[31:0]};
            rspQ.push_back('{due: edgeNum + 2, tid: tid, data: q});
`ifdef CCIP_MMIO_STATS_EN
            badRd = !mapped;
`endif
        end
        if (wr) begin
            if (base == 'h28) begin
                mScratch = modelMerge(mScratch, data, is4, hi);
            end else if (base >= 'h40 && base < 'h40 + 8*NUSR) begin
                idx = (base - 'h40) / 8;
                mUsr[idx] = modelMerge(mUsr[idx], data, is4, hi);
                pulseQ.push_back('{due: edgeNum + 2, idx: idx});
            end
`ifdef CCIP_MMIO_STATS_EN
            else if (base == 'h100) clr = 1'b1;
            else badWr = 1'b1;
`endif
        end
`ifdef CCIP_MMIO_STATS_EN
        if (clr) begin
            mRdCnt = 0; mWrCnt = 0; mBadCnt = 0;
        end else begin
            mRdCnt  = mRdCnt + 32'(rd);
            mWrCnt  = mWrCnt + 32'(wr);
            mBadCnt = mBadCnt + 32'(badRd) + 32'(badWr);
        end
`endif
    endtask

    task automatic checkCycle();
        if (rspQ.size() > 0 && rspQ[0].due == edgeNum) begin
            checkOutput("c2_valid", 64'(c2.mmioRdValid), 64'd1);
            checkOutput("c2_tid", 64'(c2.hdr.tid), 64'(rspQ[0].tid));
            checkOutput("c2_data", c2.data, rspQ[0].data);
            rspQ.delete(0);
        end else begin
            checkOutput("c2_quiet", 64'(c2.mmioRdValid), 64'd0);
        end
        if (pulseQ.size() > 0 && pulseQ[0].due == edgeNum) begin
            checkOutput("wr_pulse", 64'(wrValid), 64'd1);
            checkOutput("wr_idx", 64'(wrIdx), 64'(pulseQ[0].idx));
            pulseQ.delete(0);
        end else begin
            checkOutput("wr_quiet", 64'(wrValid), 64'd0);
        end
    endtask

    task automatic applyStimulus(input bit rd, input bit wr, input logic [15:0] addr,
                                 input logic [1:0] len, input logic [8:0] tid, input logic [63:0] data);
        @(negedge pClk);
        rx.c0.mmioRdValid = rd;
        rx.c0.mmioWrValid = wr;
        rx.c0.hdr.address = addr;
        rx.c0.hdr.length  = len;
        rx.c0.hdr.tid     = tid;
        rx.c0.data        = data;
        modelAccept(rd, wr, addr, len, tid, data);
        @(posedge pClk);
        #1;
        checkCycle();
    endtask

    task automatic doRead(input int ofs, input bit is8, input logic [8:0] tid);
        applyStimulus(1'b1, 1'b0, 16'(ofs >> 2), is8 ? 2'd1 : 2'd0, tid, 64'd0);
    endtask

    task automatic doWrite(input int ofs, input bit is8, input logic [63:0] data);
        applyStimulus(1'b0, 1'b1, 16'(ofs >> 2), is8 ? 2'd1 : 2'd0, 9'd0, data);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 16'd0, 2'd0, 9'd0, 64'd0);
    endtask

    task automatic checkUsr();
        for (int i = 0; i < NUSR; i++)
            checkOutput($sformatf("usr_csr%0d", i), usrCsr[64*i +: 64], mUsr[i]);
    endtask

    // Reset drops every in-flight response and pulse, so the expectation queues are flushed.
    task automatic applyReset(input int n);
        @(negedge pClk);
        pReset = 1'b1;
        rx     = '0;
        rspQ.delete();
        pulseQ.delete();
        mScratch = '0;
        for (int i = 0; i < NUSR; i++) mUsr[i] = '0;
`ifdef CCIP_MMIO_STATS_EN
        mRdCnt = 0; mWrCnt = 0; mBadCnt = 0;
`endif
        for (int c = 0; c < n; c++) begin
            @(posedge pClk);
            #1;
            checkOutput("rst_c2_valid", 64'(c2.mmioRdValid), 64'd0);
            checkOutput("rst_c2_tid", 64'(c2.hdr.tid), 64'd0);
            checkOutput("rst_c2_data", c2.data, 64'd0);
            checkOutput("rst_wr_valid", 64'(wrValid), 64'd0);
            checkOutput("rst_wr_idx", 64'(wrIdx), 64'd0);
        end
        checkUsr();
        pReset = 1'b0;
    endtask

    initial begin
        int mixOfs[16] = '{'h00, 'h08, 'h10, 'h18, 'h20, 'h28, 'h2C, 'h30,
                           'h3F8, 'h40, 'h44, 'h78, 'h7C, 'h80, 'h38, 'h10};
        pReset     = 1'b1;
        rx         = '0;
        modeStatus = 64'h0;

        applyReset(3);

        doRead('h00, 1'b1, 9'h1A5);
        idleCycles(3);

        doWrite('h28, 1'b1, 64'hDEAD_BEEF_CAFE_F00D);
        doRead('h28, 1'b1, 9'h011);
        doRead('h2C, 1'b0, 9'h012);
        idleCycles(3);

        doWrite('h44, 1'b0, 64'h0000_0000_1234_5678);
        idleCycles(3);
        checkUsr();

        for (int i = 0; i < 16; i++) doRead(mixOfs[i], i[0], 9'(9'h100 + i));
        idleCycles(3);

        modeStatus = 64'hA;
`ifdef CCIP_MMIO_STATS_EN
        doWrite('h100, 1'b1, 64'h0);
`endif
        doWrite('h30, 1'b1, 64'h55);
        idleCycles(2);
        doRead('h30, 1'b1, 9'h030);
`ifdef CCIP_MMIO_STATS_EN
        idleCycles(2);
        doRead('h110, 1'b1, 9'h110);
`endif
        idleCycles(3);

        doRead('h20, 1'b0, 9'h0AA);
        doWrite('h28, 1'b1, 64'h1111_2222_3333_4444);
        applyReset(2);
        idleCycles(3);

        modeStatus = {$urandom, $urandom};
        for (int n = 0; n < 300; n++) begin
            int kind = $urandom_range(0, 7);
            logic [15:0] addr = ($urandom_range(0, 15) == 0) ? 16'h00FE : 16'($urandom_range(0, 'h23));
            applyStimulus(kind <= 3 || kind == 6, kind == 4 || kind == 5 || kind == 6, addr,
                          2'($urandom_range(0, 3)), 9'($urandom), {$urandom, $urandom});
        end
        idleCycles(4);
        checkUsr();
        doRead('h28, 1'b1, 9'h1FF);
        idleCycles(3);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
